// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
// alu_seq_n : registered W-bit ALU, 7 single-cycle ops + sequential multiply
// Rev 1.0
// ============================================================================
module alu_seq_n #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   op,
   output logic [W-1:0] res,
   output logic [W-1:0] res_hi,
   output logic         out_valid,
   output logic         busy,
   output logic         flag_n,
   output logic         flag_z,
   output logic         flag_c,
   output logic         flag_v
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nx;

   logic [2*W-1:0] r_ma;
   logic [W-1:0]   r_mb;
   logic [2*W-1:0] r_acc;
   logic [CW-1:0]  r_cnt;

   logic [W-1:0]   r_res;
   logic [W-1:0]   r_res_hi;
   logic           r_valid;
   logic           r_n;
   logic           r_z;
   logic           r_c;
   logic           r_v;

   logic           w_accept;
   logic           w_last_step;
   logic [W:0]     w_sum;
   logic [W:0]     w_diff;
   logic [W-1:0]   w_res;
   logic           w_c;
   logic           w_v;
   logic [2*W-1:0] w_acc_nx;
   logic [W-1:0]   w_prod_hi;

   assign w_accept    = start && (r_state == S_IDLE);
   assign w_last_step = (r_state == S_MUL) && (r_cnt == CW'(1));
   assign w_sum       = {1'b0, a} + {1'b0, b};
   assign w_diff      = {1'b0, a} - {1'b0, b};
   assign w_acc_nx    = r_acc + (r_mb[0] ? r_ma : '0);
   assign w_prod_hi   = w_acc_nx[2*W-1:W];

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (start && op == 3'd7) w_state_nx = S_MUL;
         S_MUL:   if (r_cnt == CW'(1))     w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Single-cycle ops; the borrow-free flag for sub is the inverted extension bit.
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op)
         3'd0: begin
            w_res = w_sum[W-1:0];
            w_c   = w_sum[W];
            w_v   = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
         end
         3'd1: begin
            w_res = w_diff[W-1:0];
            w_c   = ~w_diff[W];
            w_v   = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
         end
         3'd2: begin
            w_res = a >> 1;
            w_c   = a[0];
         end
         3'd3: begin
            w_res = a << 1;
            w_c   = a[W-1];
         end
         3'd4:    w_res = a & b;
         3'd5:    w_res = a | b;
         3'd6:    w_res = a ^ b;
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ma     <= '0;
         r_mb     <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_res    <= '0;
         r_res_hi <= '0;
         r_valid  <= 1'b0;
         r_n      <= 1'b0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            if (op == 3'd7) begin
               r_ma  <= {{W{1'b0}}, a};
               r_mb  <= b;
               r_acc <= '0;
               r_cnt <= CW'(W);
            end else begin
               r_res    <= w_res;
               r_res_hi <= '0;
               r_n      <= w_res[W-1];
               r_z      <= (w_res == '0);
               r_c      <= w_c;
               r_v      <= w_v;
               r_valid  <= 1'b1;
            end
         end else if (r_state == S_MUL) begin
            r_acc <= w_acc_nx;
            r_ma  <= r_ma << 1;
            r_mb  <= r_mb >> 1;
            r_cnt <= r_cnt - CW'(1);
            if (w_last_step) begin
               r_res    <= w_acc_nx[W-1:0];
               r_res_hi <= w_prod_hi;
               r_n      <= 1'b0;
               r_z      <= (w_acc_nx == '0);
               r_c      <= (w_prod_hi != '0);
               r_v      <= (w_prod_hi != '0);
               r_valid  <= 1'b1;
            end
         end
      end
   end

   assign res       = r_res;
   assign res_hi    = r_res_hi;
   assign out_valid = r_valid;
   assign busy      = (r_state == S_MUL);
   assign flag_n    = r_n;
   assign flag_z    = r_z;
   assign flag_c    = r_c;
   assign flag_v    = r_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_n.sv
`default_nettype none
// ============================================================================
// tb_alu_seq_n : directed + randomized checks of alu_seq_n against a model
// Rev 1.0
// ============================================================================
module tb_alu_seq_n;

   localparam int W  = 4;
   localparam int OW = 2*W + 6;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic [W-1:0] res;
   logic [W-1:0] res_hi;
   logic         out_valid;
   logic         busy;
   logic         flag_n;
   logic         flag_z;
   logic         flag_c;
   logic         flag_v;

   int n_checks = 0;
   int n_errors = 0;

   // {res_hi, res, n, z, c, v} last registered result
   logic [2*W+3:0] r_hold;

   alu_seq_n #(.W(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .op        (op),
      .res       (res),
      .res_hi    (res_hi),
      .out_valid (out_valid),
      .busy      (busy),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [OW-1:0] obs();
      return {res_hi, res, flag_n, flag_z, flag_c, flag_v, out_valid, busy};
   endfunction

   // Reference from arithmetic definitions using wide signed integers.
   function automatic logic [2*W+3:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      longint m  = longint'(1) << W;
      longint ux = longint'(x);
      longint uy = longint'(y);
      longint sx = (ux >= m/2) ? ux - m : ux;
      longint sy = (uy >= m/2) ? uy - m : uy;
      longint r  = 0;
      longint hi = 0;
      longint s  = 0;
      logic   n, z, c, v;
      c = 1'b0;
      v = 1'b0;
      case (o)
         3'd0: begin
            r = ux + uy; c = (r >= m); r = r % m;
            s = sx + sy; v = (s >= m/2) || (s < -m/2);
         end
         3'd1: begin
            r = (ux - uy + m) % m; c = (ux >= uy);
            s = sx - sy; v = (s >= m/2) || (s < -m/2);
         end
         3'd2: begin r = ux / 2;       c = (ux % 2) == 1; end
         3'd3: begin r = (ux * 2) % m; c = (ux >= m/2);   end
         3'd4: r = longint'(x & y);
         3'd5: r = longint'(x | y);
         3'd6: r = longint'(x ^ y);
         default: begin
            s = ux * uy; r = s % m; hi = s / m;
            c = (hi != 0); v = c;
         end
      endcase
      n = (o == 3'd7) ? 1'b0 : (r >= m/2);
      z = (r == 0) && (hi == 0);
      return {hi[W-1:0], r[W-1:0], n, z, c, v};
   endfunction

   task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
      if (o != 3'd7) begin
         r_hold = model(o, x, y);
         chk("alu", 64'(obs()), 64'({r_hold, 2'b10}));
      end else begin
         for (int i = 1; i <= W; i++) begin
            chk("mul_busy", 64'(obs()), 64'({r_hold, 2'b01}));
            if (poke) begin
               start = 1'b1;
               op    = 3'($urandom_range(0, 7));
               a     = W'($urandom);
               b     = W'($urandom);
            end
            tick();
            start = 1'b0;
         end
         r_hold = model(o, x, y);
         chk("mul", 64'(obs()), 64'({r_hold, 2'b10}));
      end
   endtask

   task automatic idle_chk(input string tag);
      tick();
      chk(tag, 64'(obs()), 64'({r_hold, 2'b00}));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
      r_hold = '0;
      tick(); tick();
      chk("reset", 64'(obs()), 64'(0));
      start = 1'b1; op = 3'd0; a = 4'd3; b = 4'd4;
      tick();
      chk("reset_start", 64'(obs()), 64'(0));
      start = 1'b0; rst_n = 1'b1;
      idle_chk("idle");

      do_op(3'd0, 4'b0111, 4'b0001, 1'b0);
      chk("add_v", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(4'b1001));
      do_op(3'd0, 4'b1111, 4'b0001, 1'b0);
      chk("add_zc", 64'({res, flag_z, flag_c}), 64'(6'b000011));
      do_op(3'd1, 4'b0011, 4'b0101, 1'b0);
      chk("sub_neg", 64'({res, flag_n, flag_c, flag_v}), 64'(7'b1110100));
      do_op(3'd1, 4'b1000, 4'b0001, 1'b0);
      chk("sub_ovf", 64'({res, flag_v, flag_c}), 64'(6'b011111));
      idle_chk("pulse_once");
      do_op(3'd3, 4'b1001, 4'b0000, 1'b0);
      chk("shl", 64'({res, flag_c}), 64'(5'b00101));
      do_op(3'd2, 4'b1001, 4'b0000, 1'b0);
      chk("shr", 64'({res, flag_c}), 64'(5'b01001));
      do_op(3'd4, 4'b1010, 4'b0101, 1'b0);
      chk("and_z", 64'({res, flag_z}), 64'(5'b00001));

      do_op(3'd7, 4'b1111, 4'b1111, 1'b1);
      chk("mul_ff", 64'({res_hi, res, flag_c, flag_v}), 64'(10'b1110000111));
      idle_chk("mul_pulse_once");

      // Reset mid-multiply aborts it without a result pulse.
      start = 1'b1; op = 3'd7; a = 4'b0011; b = 4'b0010;
      tick();
      start = 1'b0;
      chk("abort_busy", 64'(busy), 64'(1));
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      r_hold = '0;
      chk("abort_rst", 64'(obs()), 64'(0));
      for (int i = 0; i < W + 1; i++) idle_chk("abort_quiet");
      do_op(3'd0, 4'b0001, 4'b0001, 1'b0);
      chk("post_abort", 64'(res), 64'(2));

      for (int i = 0; i < 300; i++) begin
         do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle_chk("rand_idle");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/alu_seq_n.md
# alu_seq_n

Parametrised, registered ALU for the FPGA datapath: the N-bit successor to the 4-bit combinational ALU. It keeps the seven existing operations (add, sub, shift right, shift left, and, or, xor) and adds an unsigned sequential shift-add multiply. Operands are captured on a start handshake; result and N/Z/C/V flags are held in registers until the next result. It sits between the switch/key input logic and the bin2bcd/7-segment display path.

## Interface

- W, default 4: operand and result width; W ≥ 2.
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; operands and op sampled on a clk edge where start=1 and busy=0.
- a  input  W  operand A (unsigned, or two's complement for V/N interpretation).
- b  input  W  operand B.
- op  input  3  0 add, 1 sub, 2 A>>1, 3 A<<1, 4 and, 5 or, 6 xor, 7 multiply.
- res  output  W  result (low half for multiply).
- res_hi  output  W  high half of product for op 7; 0 for all other ops.
- out_valid  output  1  one-cycle pulse when res/res_hi/flags update.
- busy  output  1  high while a multiply is in progress.
- flag_n, flag_z, flag_c, flag_v  output  1 each  registered N, Z, C, V flags.

## Operation

- States: IDLE, MUL. Reset → IDLE.
- IDLE, accepted start with op 0–6: result and flags computed and registered at the accept edge; out_valid=1 for the next cycle; remain in IDLE.
- IDLE, accepted start with op 7: latch a, b; clear the product accumulator; load iteration counter = W; go to MUL; busy=1.
- MUL: one shift-add step per cycle, counter decrements. After the step where the counter reaches 0, register the product and flags, pulse out_valid, return to IDLE, busy=0.
- Start while busy=1 is ignored, with no side effects and not queued.
- Flag rules:
  - add: res = (a+b) mod 2^W; C = carry out; V = signed overflow; N = res[W-1].
  - sub: res = (a−b) mod 2^W in two's complement (no magnitude conversion); C = 1 iff a ≥ b unsigned (no borrow); V = signed overflow; N = res[W-1].
  - shr/shl: logical, zero fill; C = bit shifted out (a[0] for shr, a[W-1] for shl); V = 0; N = res[W-1].
  - and/or/xor: C = V = 0; N = res[W-1].
  - mul: {res_hi,res} = a*b unsigned; C = V = (res_hi ≠ 0); N = 0.
  - Z = 1 iff every result bit is 0 ({res_hi,res} for mul). Z is valid for every op, including a zero result from add.
- res, res_hi and the flags hold their values between results. They are not disturbed while a multiply is in flight.

## Timing

- Reset (rst_n=0 at an edge): state IDLE; res, res_hi, out_valid, busy and all flags = 0; any multiply in progress is aborted with no out_valid. Reset dominates start at the same edge.
- Ops 0–6: accepted at edge k → outputs valid and out_valid=1 during cycle k+1. Back-to-back starts every cycle are allowed, giving out_valid high continuously.
- Op 7: accepted at edge k → busy=1 in cycles k+1…k+W. Result, flags and out_valid=1 appear in cycle k+W+1, with busy=0 in that cycle. A new start can be accepted at the edge ending cycle k+W+1.
- Operand/op changes after acceptance have no effect on the in-flight operation.
- out_valid is never high for two cycles from a single request.

## Test plan

- W=4, reset then idle: all outputs 0; start=1 with rst_n=0 → still all 0, busy=0.
- add a=0111, b=0001 → res=1000, flag_n=1, flag_v=1, flag_c=0, flag_z=0, out_valid one cycle after start. Then add 1111+0001 → res=0000, flag_c=1, flag_z=1.
- sub a=0011, b=0101 → res=1110, flag_n=1, flag_c=0, flag_v=0. Then sub 1000−0001 → res=0111, flag_v=1, flag_c=1.
- shl a=1001 → res=0010, flag_c=1. shr a=1001 → res=0100, flag_c=1. and 1010&0101 → res=0000, flag_z=1.
- mul a=1111, b=1111 accepted at edge k → busy high cycles k+1…k+4; cycle k+5: res_hi=1110, res=0001, flag_c=flag_v=1. A start (add) asserted during busy is ignored, and the old res holds until k+5.
- mul 0011×0010 with rst_n=0 at edge k+2 → busy=0 and all outputs 0 from k+3; no out_valid. A following add 0001+0001 → res=0010, normal latency.
